// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - op codes, scheduler states and gravity default for the Tetris move path
package tetris_pkg;

  localparam int GRAVITY_TICKS_DEF = 25_000_000;

  typedef enum logic [1:0] {
    MV_LEFT  = 2'b00,
    MV_RIGHT = 2'b01,
    MV_ROT   = 2'b10,
    MV_DOWN  = 2'b11
  } mv_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT      = 2'b01,
    LOCK      = 2'b10,
    LOCK_WAIT = 2'b11
  } sched_state_t;

  // Pending vector layout is {down, rot, left, right}; down wins, right loses.
  function automatic mv_op_t pick_op(input logic [3:0] p);
    if (p[3])      return MV_DOWN;
    else if (p[2]) return MV_ROT;
    else if (p[1]) return MV_LEFT;
    else           return MV_RIGHT;
  endfunction

  function automatic logic [3:0] op_mask(input mv_op_t op);
    case (op)
      MV_LEFT:  return 4'b0010;
      MV_RIGHT: return 4'b0001;
      MV_ROT:   return 4'b0100;
      default:  return 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - move req/ack handshake between scheduler and board datapath
interface move_scheduler_if;
  import tetris_pkg::*;

  logic   mv_req;
  mv_op_t mv_op;
  logic   mv_ack;
  logic   mv_ok;
  logic   lock_p;
  logic   spawn_done;

  modport master (
    output mv_req, mv_op, lock_p,
    input  mv_ack, mv_ok, spawn_done
  );

  modport slave (
    input  mv_req, mv_op, lock_p,
    output mv_ack, mv_ok, spawn_done
  );

endinterface

// File: rtl/gravity_timer.sv
// rtl/gravity_timer.sv - gravity step counter with one-cycle tick; SOFT_DROP_EN shortens the period
module gravity_timer #(
  parameter int GRAVITY_TICKS = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  input  logic soft_drop,
  output logic tick
);

  localparam int W = $clog2(GRAVITY_TICKS);
  localparam logic [W-1:0] WRAP_NORM = W'(GRAVITY_TICKS - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] wrap_at;

`ifdef SOFT_DROP_EN
  localparam logic [W-1:0] WRAP_SOFT = W'((GRAVITY_TICKS >> 3) - 1);
  assign wrap_at = soft_drop ? WRAP_SOFT : WRAP_NORM;
`else
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop;
  assign wrap_at = WRAP_NORM;
`endif

  // >= so a counter already past the soft-drop threshold wraps immediately
  assign tick = run && !clear && (cnt >= wrap_at);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - latches move requests, grants by priority, drives datapath handshake; option SOFT_DROP_EN
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = GRAVITY_TICKS_DEF
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      left_p,
  input  logic                      right_p,
  input  logic                      rot_p,
  input  logic                      soft_drop,
  move_scheduler_if.master          mv,
  output logic                      busy,
  output logic [3:0]                pend
);

  sched_state_t state, state_n;
  mv_op_t       op_q, op_n;
  logic [3:0]   pend_q, pend_n;
  logic         grav_tick;
  logic         grant;
  logic         keys_ok;
  logic [3:0]   set_v;
  logic [3:0]   clr_v;

  gravity_timer #(
    .GRAVITY_TICKS (GRAVITY_TICKS)
  ) u_gravity (
    .clk       (CLOCK_50),
    .resetn    (resetn),
    .run       (enable && (state != LOCK_WAIT)),
    .clear     (!enable || (state == LOCK)),
    .soft_drop (soft_drop),
    .tick      (grav_tick)
  );

  always_comb begin
    state_n = state;
    op_n    = op_q;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|pend_q)) begin
          grant   = 1'b1;
          op_n    = pick_op(pend_q);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (mv.mv_ack) begin
          state_n = ((op_q == MV_DOWN) && !mv.mv_ok) ? LOCK : IDLE;
        end
      end
      LOCK:      state_n = LOCK_WAIT;
      LOCK_WAIT: begin
        if (mv.spawn_done) state_n = IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end

  // Keys are dropped from the lock pulse until the new piece is placed.
  always_comb begin
    keys_ok = (state == IDLE) || (state == WAIT);
    set_v   = {grav_tick, {rot_p, left_p, right_p} & {3{keys_ok}}};
    clr_v   = grant ? op_mask(op_n) : 4'b0000;
    if (state == LOCK) clr_v = clr_v | 4'b0111;
    pend_n  = enable ? ((pend_q & ~clr_v) | set_v) : 4'b0000;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      op_q   <= MV_LEFT;
      pend_q <= 4'b0000;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      pend_q <= pend_n;
    end
  end

  assign mv.mv_req = (state == WAIT);
  assign mv.mv_op  = op_q;
  assign mv.lock_p = (state == LOCK);
  assign busy      = (state != IDLE);
  assign pend      = pend_q;

endmodule
